// File: rtl/dram_line_cache_if.sv
// CPU-side request/response port and DRAM command/return port of the line cache.
// The cache uses the slave view; the environment (CPU + DRAM) uses the master view.
// Pure wiring, no logic.
interface dram_line_cache_if;
  // CPU side
  logic        w_i_rd;
  logic        w_i_wr;
  logic [31:0] w_i_addr;
  logic [31:0] w_i_data;
  logic [3:0]  w_i_mask;
  logic        w_i_flush;
  logic [31:0] w_o_rdata;
  logic        w_o_rvalid;
  logic        w_o_busy;
  // DRAM side
  logic        w_o_dram_rd_en;
  logic        w_o_dram_wr_en;
  logic [31:0] w_o_dram_addr;
  logic [31:0] w_o_dram_data;
  logic [3:0]  w_o_dram_mask;
  logic [31:0] w_i_dram_data0;
  logic [31:0] w_i_dram_data1;
  logic [31:0] w_i_dram_data2;
  logic [31:0] w_i_dram_data3;
  logic        w_i_dram_busy;

  modport slave (
    input  w_i_rd, w_i_wr, w_i_addr, w_i_data, w_i_mask, w_i_flush,
    input  w_i_dram_data0, w_i_dram_data1, w_i_dram_data2, w_i_dram_data3, w_i_dram_busy,
    output w_o_rdata, w_o_rvalid, w_o_busy,
    output w_o_dram_rd_en, w_o_dram_wr_en, w_o_dram_addr, w_o_dram_data, w_o_dram_mask
  );

  modport master (
    output w_i_rd, w_i_wr, w_i_addr, w_i_data, w_i_mask, w_i_flush,
    output w_i_dram_data0, w_i_dram_data1, w_i_dram_data2, w_i_dram_data3, w_i_dram_busy,
    input  w_o_rdata, w_o_rvalid, w_o_busy,
    input  w_o_dram_rd_en, w_o_dram_wr_en, w_o_dram_addr, w_o_dram_data, w_o_dram_mask
  );
endinterface

// File: rtl/dram_line_cache.sv
// Direct-mapped, write-through, no-write-allocate cache of 16-byte lines in front of DRAM.
// Latency: read hit 1 cycle; read miss / write 4 cycles plus one per DRAM busy cycle in REQ/WAIT.
// Backpressure: w_o_busy high while a transaction is outstanding; requests wait until it drops.
module dram_line_cache #(
  parameter int LINES = 64
) (
  input  logic              w_CLK,
  input  logic              w_rst_n,
  dram_line_cache_if.slave  bus
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = 28 - IDX;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT1, RD_WAIT, WR_REQ, WR_WAIT1, WR_WAIT
  } state_t;

  state_t state, state_nxt;

  // Storage: only the valid bits are reset; tags/data are don't-care while invalid.
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][4];

  // Latched request for the outstanding transaction
  logic [31:2] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic        flush_pend;

  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        rd_en, wr_en;

  // Incoming request address split
  logic [IDX-1:0] in_idx;
  logic [TW-1:0]  in_tag;
  logic [1:0]     in_off;
  assign in_idx = bus.w_i_addr[4+IDX-1:4];
  assign in_tag = bus.w_i_addr[31:4+IDX];
  assign in_off = bus.w_i_addr[3:2];

  // Latched request address split
  logic [IDX-1:0] req_idx;
  logic [TW-1:0]  req_tag;
  logic [1:0]     req_off;
  assign req_idx = req_addr[4+IDX-1:4];
  assign req_tag = req_addr[31:4+IDX];
  assign req_off = req_addr[3:2];

  logic idle, hit, acc_wr, acc_rd, rd_miss, fill_done, to_idle, clr_all;
  assign idle      = (state == IDLE);
  assign hit       = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
  assign acc_wr    = idle && bus.w_i_wr;
  assign acc_rd    = idle && bus.w_i_rd && !bus.w_i_wr;
  assign rd_miss   = acc_rd && !hit;
  assign fill_done = (state == RD_WAIT) && !bus.w_i_dram_busy;
  assign to_idle   = ((state == RD_WAIT) || (state == WR_WAIT)) && !bus.w_i_dram_busy;
  // A flush raised mid-transaction waits for the return to IDLE and beats the fill's valid set.
  assign clr_all   = (idle && bus.w_i_flush) ||
                     (to_idle && (flush_pend || bus.w_i_flush));

  logic [31:0] fill_word [4];
  assign fill_word[0] = bus.w_i_dram_data0;
  assign fill_word[1] = bus.w_i_dram_data1;
  assign fill_word[2] = bus.w_i_dram_data2;
  assign fill_word[3] = bus.w_i_dram_data3;

  // Write-hit merge: mask bit set keeps the cached byte
  logic [31:0] merged;
  always_comb begin
    merged = data_mem[in_idx][in_off];
    for (int b = 0; b < 4; b++) begin
      if (!bus.w_i_mask[b]) merged[8*b +: 8] = bus.w_i_data[8*b +: 8];
    end
  end

  // State register; reset drops the strobes asynchronously through the state decode
  always_ff @(posedge w_CLK or negedge w_rst_n) begin
    if (!w_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and one-cycle DRAM command strobes
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (acc_wr)       state_nxt = WR_REQ;
        else if (rd_miss) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        if (!bus.w_i_dram_busy) begin
          rd_en     = 1'b1;
          state_nxt = RD_WAIT1;
        end
      end
      RD_WAIT1: state_nxt = RD_WAIT;
      RD_WAIT:  if (!bus.w_i_dram_busy) state_nxt = IDLE;
      WR_REQ: begin
        if (!bus.w_i_dram_busy) begin
          wr_en     = 1'b1;
          state_nxt = WR_WAIT1;
        end
      end
      WR_WAIT1: state_nxt = WR_WAIT;
      WR_WAIT:  if (!bus.w_i_dram_busy) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Response register, valid bits, pending flush and latched request
  always_ff @(posedge w_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      valid_q    <= '0;
      flush_pend <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      req_mask   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (acc_rd && hit) begin
        rdata_q  <= data_mem[in_idx][in_off];
        rvalid_q <= 1'b1;
      end
      if (fill_done) begin
        rdata_q  <= fill_word[req_off];
        rvalid_q <= 1'b1;
        valid_q[req_idx] <= 1'b1;
      end
      if (clr_all) valid_q <= '0;

      if (clr_all)                        flush_pend <= 1'b0;
      else if (!idle && bus.w_i_flush)    flush_pend <= 1'b1;

      if (acc_wr || rd_miss) begin
        req_addr <= bus.w_i_addr[31:2];
        req_data <= bus.w_i_data;
        req_mask <= bus.w_i_mask;
      end
    end
  end

  // Tag/data arrays: line fill on miss return, byte merge on write hit
  always_ff @(posedge w_CLK) begin
    if (fill_done) begin
      tag_mem[req_idx] <= req_tag;
      for (int w = 0; w < 4; w++) data_mem[req_idx][w] <= fill_word[w];
    end
    if (acc_wr && hit) data_mem[in_idx][in_off] <= merged;
  end

  logic wr_phase;
  assign wr_phase = (state == WR_REQ) || (state == WR_WAIT1) || (state == WR_WAIT);

  assign bus.w_o_rdata      = rdata_q;
  assign bus.w_o_rvalid     = rvalid_q;
  assign bus.w_o_busy       = !idle;
  assign bus.w_o_dram_rd_en = rd_en;
  assign bus.w_o_dram_wr_en = wr_en;
  assign bus.w_o_dram_addr  = wr_phase ? {req_addr[31:2], 2'b00} : {req_addr[31:4], 4'h0};
  assign bus.w_o_dram_data  = req_data;
  assign bus.w_o_dram_mask  = req_mask;

endmodule

// File: tb/tb_dram_line_cache.sv
// Bench for dram_line_cache: directed CPU requests against a behavioural DRAM,
// with read data and DRAM commands checked by a queue-based scoreboard monitor.
module tb_dram_line_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_line_cache_if bus ();

  dram_line_cache #(.LINES(64)) dut (
    .w_CLK   (clk),
    .w_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int          cyc;
  } cmd_t;

  logic [31:0] rd_q_data [$];
  int          rd_q_cyc  [$];
  string       rd_q_nm   [$];
  cmd_t        cmd_q     [$];

  // Behavioural DRAM: unwritten words read as {addr[15:0], ~addr[15:0]}
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor and DRAM model, sampled on the falling edge
  cmd_t        c;
  logic [31:0] exp_d;
  int          exp_c;
  string       nm;
  logic [31:0] old;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.w_o_rvalid) begin
        if (rd_q_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected rvalid: got data %h expected no response", bus.w_o_rdata);
        end else begin
          exp_d = rd_q_data.pop_front();
          exp_c = rd_q_cyc.pop_front();
          nm    = rd_q_nm.pop_front();
          chk({nm, " rdata"}, bus.w_o_rdata, exp_d);
          chk({nm, " rvalid cycle"}, cyc, exp_c);
        end
      end
      if (bus.w_o_dram_rd_en || bus.w_o_dram_wr_en) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected dram cmd: got rd %b wr %b addr %h expected none",
                   bus.w_o_dram_rd_en, bus.w_o_dram_wr_en, bus.w_o_dram_addr);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd wr_en", {31'd0, bus.w_o_dram_wr_en}, {31'd0, c.wr});
          chk("cmd rd_en", {31'd0, bus.w_o_dram_rd_en}, {31'd0, !c.wr});
          chk("cmd addr", bus.w_o_dram_addr, c.addr);
          chk("cmd cycle", cyc, c.cyc);
          if (c.wr) begin
            chk("cmd data", bus.w_o_dram_data, c.data);
            chk("cmd mask", {28'd0, bus.w_o_dram_mask}, {28'd0, c.mask});
          end
        end
        if (bus.w_o_dram_rd_en) begin
          bus.w_i_dram_data0 = mem_rd(bus.w_o_dram_addr);
          bus.w_i_dram_data1 = mem_rd(bus.w_o_dram_addr + 32'd4);
          bus.w_i_dram_data2 = mem_rd(bus.w_o_dram_addr + 32'd8);
          bus.w_i_dram_data3 = mem_rd(bus.w_o_dram_addr + 32'd12);
        end
        if (bus.w_o_dram_wr_en) begin
          old = mem_rd(bus.w_o_dram_addr);
          for (int b = 0; b < 4; b++)
            if (!bus.w_o_dram_mask[b]) old[8*b +: 8] = bus.w_o_dram_data[8*b +: 8];
          mem[bus.w_o_dram_addr] = old;
        end
      end
    end
  end

  // Read request: lat/cmd_lat are cycles after the drive point to rvalid / rd_en
  task automatic rd_req(input logic [31:0] a, input logic [31:0] d, input string name,
                        input bit exp_rv, input int lat, input bit miss, input int cmd_lat);
    cmd_t e;
    if (exp_rv) begin
      rd_q_data.push_back(d);
      rd_q_cyc.push_back(cyc + lat);
      rd_q_nm.push_back(name);
    end
    if (miss) begin
      e.wr = 1'b0; e.addr = {a[31:4], 4'h0}; e.data = '0; e.mask = '0; e.cyc = cyc + cmd_lat;
      cmd_q.push_back(e);
    end
    bus.w_i_rd   = 1'b1;
    bus.w_i_addr = a;
    @(posedge clk); #1;
    bus.w_i_rd   = 1'b0;
  endtask

  task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cmd_t e;
    e.wr = 1'b1; e.addr = {a[31:2], 2'b00}; e.data = d; e.mask = m; e.cyc = cyc + 1;
    cmd_q.push_back(e);
    bus.w_i_wr   = 1'b1;
    bus.w_i_addr = a;
    bus.w_i_data = d;
    bus.w_i_mask = m;
    @(posedge clk); #1;
    bus.w_i_wr   = 1'b0;
  endtask

  // Count busy-high falling edges until idle (bounded), then move to the next drive point
  task automatic wait_idle(input int exp_busy, input string name);
    int n = 0;
    @(negedge clk);
    while (bus.w_o_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, n, exp_busy);
    @(posedge clk); #1;
  endtask

  task automatic flush_pulse();
    bus.w_i_flush = 1'b1;
    @(posedge clk); #1;
    bus.w_i_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.w_i_rd = 1'b0; bus.w_i_wr = 1'b0; bus.w_i_addr = '0; bus.w_i_data = '0;
    bus.w_i_mask = '0; bus.w_i_flush = 1'b0; bus.w_i_dram_busy = 1'b0;
    bus.w_i_dram_data0 = '0; bus.w_i_dram_data1 = '0;
    bus.w_i_dram_data2 = '0; bus.w_i_dram_data3 = '0;
    mem[32'h1004] = 32'hDEADBEEF;
    mem[32'h1008] = 32'h0BADF00D;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   {31'd0, bus.w_o_busy},       32'd0);
    chk("reset rvalid", {31'd0, bus.w_o_rvalid},     32'd0);
    chk("reset rdata",  bus.w_o_rdata,               32'd0);
    chk("reset rd_en",  {31'd0, bus.w_o_dram_rd_en}, 32'd0);
    chk("reset wr_en",  {31'd0, bus.w_o_dram_wr_en}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Miss fill, then hits from the same line (back-to-back)
    rd_req(32'h1004, 32'hDEADBEEF, "miss 1004", 1, 4, 1, 1);
    wait_idle(3, "miss 1004");
    rd_req(32'h1008, 32'h0BADF00D, "hit 1008", 1, 1, 0, 0);
    rd_req(32'h100C, 32'h100CEFF3, "hit 100c", 1, 1, 0, 0);
    wait_idle(0, "hit 100c");

    // Write hit merges into the line; write miss does not allocate
    wr_req(32'h1004, 32'h11223344, 4'b1100);
    wait_idle(3, "write 1004");
    rd_req(32'h1004, 32'hDEAD3344, "hit 1004 merged", 1, 1, 0, 0);
    wait_idle(0, "hit 1004 merged");
    wr_req(32'h3000, 32'hCAFEF00D, 4'b0000);
    wait_idle(3, "write 3000");
    rd_req(32'h3000, 32'hCAFEF00D, "miss 3000", 1, 4, 1, 1);
    wait_idle(3, "miss 3000");

    // Same index, different tags: each access refills
    rd_req(32'h1000, 32'h1000EFFF, "conflict 1000 a", 1, 4, 1, 1);
    wait_idle(3, "conflict 1000 a");
    rd_req(32'h1400, 32'h1400EBFF, "conflict 1400", 1, 4, 1, 1);
    wait_idle(3, "conflict 1400");
    rd_req(32'h1000, 32'h1000EFFF, "conflict 1000 b", 1, 4, 1, 1);
    wait_idle(3, "conflict 1000 b");

    // Flush in IDLE invalidates
    rd_req(32'h2000, 32'h2000DFFF, "miss 2000", 1, 4, 1, 1);
    wait_idle(3, "miss 2000");
    rd_req(32'h2000, 32'h2000DFFF, "hit 2000", 1, 1, 0, 0);
    wait_idle(0, "hit 2000");
    flush_pulse();
    rd_req(32'h2000, 32'h2000DFFF, "post-flush 2000", 1, 4, 1, 1);
    wait_idle(3, "post-flush 2000");

    // DRAM busy for 5 cycles at the start of a miss delays rd_en
    bus.w_i_dram_busy = 1'b1;
    rd_req(32'h2010, 32'h2010DFEF, "stall 2010", 1, 8, 1, 5);
    repeat (4) @(posedge clk);
    #1;
    bus.w_i_dram_busy = 1'b0;
    wait_idle(3, "stall 2010");

    // DRAM busy during write WAIT1 (ignored) and WAIT (one extra cycle)
    wr_req(32'h2014, 32'h55667788, 4'b0000);
    @(posedge clk); #1;
    bus.w_i_dram_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.w_i_dram_busy = 1'b0;
    wait_idle(1, "write 2014 wait stall");
    rd_req(32'h2014, 32'h55667788, "hit 2014", 1, 1, 0, 0);
    wait_idle(0, "hit 2014");

    // Flush during a miss overrides the fill's valid set
    rd_req(32'h2020, 32'h2020DFDF, "miss 2020", 1, 4, 1, 1);
    flush_pulse();
    wait_idle(2, "miss 2020");
    rd_req(32'h2020, 32'h2020DFDF, "refill 2020", 1, 4, 1, 1);
    wait_idle(3, "refill 2020");
    rd_req(32'h2014, 32'h55667788, "refill 2014", 1, 4, 1, 1);
    wait_idle(3, "refill 2014");

    // Reset in RD_WAIT1 aborts the fill
    rd_req(32'h2030, 32'h0, "aborted 2030", 0, 0, 1, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy",   {31'd0, bus.w_o_busy},       32'd0);
    chk("abort rd_en",  {31'd0, bus.w_o_dram_rd_en}, 32'd0);
    chk("abort rvalid", {31'd0, bus.w_o_rvalid},     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_req(32'h2030, 32'h2030DFCF, "after-reset 2030", 1, 4, 1, 1);
    wait_idle(3, "after-reset 2030");

    repeat (2) @(posedge clk);
    #1;
    chk("rvalid queue drained", rd_q_data.size(), 32'd0);
    chk("cmd queue drained",    cmd_q.size(),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
